// File: rtl/rx_multi_pkg.sv
// Shared definitions for the rx_multi UART receiver.
//   OVERSAMPLE      : ticks per bit period
//   PAR_*           : PARITY parameter encodings
//   rx_state_t      : receive FSM states
//   maj3()          : 2-of-3 majority vote used for mid-bit sampling
package rx_multi_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Oversample tick generator: one-clk pulse on tick every TICK clocks.
//   clk     : system clock
//   reset_n : async active-low reset
//   clear   : sync soft reset, same effect as reset_n
//   tick    : registered 1-clk pulse
module baud_tick #(
    parameter int TICK = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK > 1) ? $clog2(TICK) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(TICK - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_multi.sv
// UART receiver, 16x oversampled, 5..8 data bits, optional parity,
// 1 or 2 stop bits, with held character, error and overrun flags.
//   clk, reset_n, clear : clock, async reset, sync soft reset
//   rx                  : async serial line (idle high)
//   clear_flag          : acknowledge, drops flag and overrun
//   flag                : character available in char0
//   char0 [0:7]         : received character, bit 7 = LSB (first bit in)
//   parity_err          : parity mismatch for char0
//   framing_err         : a stop bit sampled low for char0
//   overrun             : a frame completed while flag was still set
module rx_multi
    import rx_multi_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       rx,
    input  logic       clear_flag,
    output logic       flag,
    output logic [0:7] char0,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun
);

    localparam int         TICK      = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ON    = (PARITY != PAR_NONE);
    localparam logic       ODD_SEL   = (PARITY == PAR_ODD);

    logic       tick;
    logic [1:0] sync;
    logic       rx_s;
    rx_state_t  state;
    logic [3:0] tcnt;
    logic [3:0] idx;
    logic [2:0] bcnt;
    logic [1:0] samp;
    logic       maj;
    logic [0:7] char1;
    logic [0:7] char_just;
    logic       par_acc;
    logic       perr_pend;
    logic       ferr_pend;
    logic       done;

    baud_tick #(.TICK(TICK)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   sync <= 2'b11;
        else if (clear) sync <= 2'b11;
        else            sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    // tcnt holds the index of the last tick seen in the current bit; the
    // start-detect tick is index 0, so idx is the index of this tick and
    // wraps 15 -> 0 into the next bit.
    assign idx       = tcnt + 4'd1;
    assign maj       = maj3(samp[1], samp[0], rx_s);
    assign char_just = char1 >> (8 - DATA_BITS);
    assign done      = tick && (state == ST_STOP) && (idx == 4'd9) && (bcnt == LAST_STOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;  tcnt <= '0;  bcnt <= '0;  samp <= '0;
            char1 <= '0;  par_acc <= 1'b0;  perr_pend <= 1'b0;  ferr_pend <= 1'b0;
        end else if (clear) begin
            state <= ST_IDLE;  tcnt <= '0;  bcnt <= '0;  samp <= '0;
            char1 <= '0;  par_acc <= 1'b0;  perr_pend <= 1'b0;  ferr_pend <= 1'b0;
        end else if (tick) begin
            tcnt <= idx;
            if (idx == 4'd7) samp[0] <= rx_s;
            if (idx == 4'd8) samp[1] <= rx_s;
            case (state)
                ST_IDLE: if (!rx_s) begin
                    state     <= ST_START;
                    tcnt      <= '0;
                    bcnt      <= '0;
                    par_acc   <= 1'b0;
                    perr_pend <= 1'b0;
                    ferr_pend <= 1'b0;
                end
                ST_START: begin
                    if (idx == 4'd9 && maj) state <= ST_IDLE;   // false start
                    else if (idx == 4'd15)  state <= ST_DATA;
                end
                ST_DATA: begin
                    if (idx == 4'd9) begin
                        char1   <= {maj, char1[0:6]};
                        par_acc <= par_acc ^ maj;
                    end
                    if (idx == 4'd15) begin
                        if (bcnt == LAST_DATA) begin
                            bcnt  <= '0;
                            state <= PAR_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            bcnt <= bcnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (idx == 4'd9)       perr_pend <= par_acc ^ maj ^ ODD_SEL;
                    else if (idx == 4'd15) state     <= ST_STOP;
                end
                ST_STOP: begin
                    if (idx == 4'd9) begin
                        if (!maj) ferr_pend <= 1'b1;
                        // Leave at the final mid-bit so a start edge in the
                        // back half of the stop bit is still caught.
                        if (bcnt == LAST_STOP) state <= ST_IDLE;
                    end else if (idx == 4'd15) begin
                        bcnt <= bcnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion beats a coincident clear_flag; overrun then holds its value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag <= 1'b0;  char0 <= 8'o377;  parity_err <= 1'b0;
            framing_err <= 1'b0;  overrun <= 1'b0;
        end else if (clear) begin
            flag <= 1'b0;  char0 <= 8'o377;  parity_err <= 1'b0;
            framing_err <= 1'b0;  overrun <= 1'b0;
        end else if (done) begin
            flag        <= 1'b1;
            char0       <= char_just;
            parity_err  <= perr_pend;
            framing_err <= ferr_pend | ~maj;
            if (flag && !clear_flag) overrun <= 1'b1;
        end else if (clear_flag) begin
            flag    <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/rx_multi.md
RX_MULTI -- requirements
Module: rx_multi

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, system clock in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..8, data bits per frame.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2, stop bits checked per frame.
REQ-006 Port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port clear, input, 1, synchronous active-high soft reset with the same effect as reset.
REQ-009 Port rx, input, 1, asynchronous serial line, idle high.
REQ-010 Port clear_flag, input, 1, synchronous acknowledge; clears flag and overrun.
REQ-011 Port flag, output, 1, a received character is available.
REQ-012 Port char0, output, [0:7], received character; bit 7 is the LSB and first received; unused MSBs read 0.
REQ-013 Port parity_err, output, 1, parity mismatch on the frame in char0.
REQ-014 Port framing_err, output, 1, a stop bit sampled low on the frame in char0.
REQ-015 Port overrun, output, 1, a frame completed while flag was already set.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser (preset to 1) before any use.
REQ-017 Tick generator: tick SHALL pulse for 1 clk every TICK = CLOCK_FREQ/(BAUD_RATE*16) clocks (integer, truncated); the counter width is $clog2(TICK).
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; there is a 4-bit tick-in-bit counter and a 3-bit data-bit counter.
REQ-019 IDLE -> START on the first tick that sees synchronised rx = 0; the tick-in-bit counter clears.
REQ-020 Bit value SHALL be the majority of 3 samples taken at ticks 7, 8 and 9 of the bit.
REQ-021 START: if the mid-bit majority is 1 (false start), return to IDLE; otherwise continue to DATA after tick 15.
REQ-022 DATA: shift each majority bit in at char1[0] (right shift toward bit 7) once per bit; after DATA_BITS bits go to PARITY if PARITY != 0, else STOP.
REQ-023 PARITY: compare the majority bit with the parity computed over the data bits (odd: XOR of data ^ bit = 1; even: = 0).
REQ-024 STOP: sample STOP_BITS stop bits; any low majority sets a pending framing error.
REQ-025 At the mid-bit of the final stop bit: char0 <= the data right-justified to bit 7 with upper bits 0; parity_err and framing_err load the pending values; flag <= 1; the FSM goes to IDLE at once, so a start edge in the second half of the stop bit is accepted.
REQ-026 Latency: flag rises exactly 1 clk after the final-stop-bit mid-sample tick.
REQ-027 If flag = 1 at completion, overrun <= 1 and char0 and the error bits are overwritten with the new frame.
REQ-028 clear_flag SHALL clear flag and overrun and is not ignored by the receive path (reception continues).
REQ-029 If completion and clear_flag occur in the same clk, completion wins: flag = 1, overrun unchanged.
REQ-030 A frame with a framing error SHALL still set flag.

Reset
REQ-031 On reset_n low (async) or clear high (sync): FSM <= IDLE, counters <= 0, synchroniser <= 1, char1 <= 0, char0 <= 8'o377, flag = parity_err = framing_err = overrun = 0.
REQ-032 Reset mid-frame SHALL abandon the frame without setting flag; reception resumes with the next start bit after release.

Structure
REQ-033 PARITY encodings, FSM state encodings and the 16x oversample constant SHALL live in the shared parameters include.
REQ-034 The tick generator SHALL be one sub-module, baud_tick (parameter TICK; ports clk, reset_n, clear, tick).

Verification
Bench parameters for all scenarios: CLOCK_FREQ=1843200, BAUD_RATE=9600 (TICK=12, 192 clk/bit).
REQ-035 8N1, send 8'h41 -> flag rises 1 clk after the stop mid-sample; char0 = 8'o101; all errors 0.
REQ-036 DATA_BITS=7, PARITY=2 (even), send 7'h55 with parity 0 -> char0 = 8'o125, parity_err = 0; send again with parity 1 -> parity_err = 1.
REQ-037 8N1, send 8'hA5 with stop = 0 -> flag = 1, char0 = 8'o245, framing_err = 1.
REQ-038 rx low for 5 tick periods, then high -> FSM back in IDLE; flag stays 0.
REQ-039 Send 8'h31 then 8'h32 without clear_flag -> char0 = 8'o062, overrun = 1; pulse clear_flag -> flag = 0, overrun = 0.
REQ-040 Assert reset_n low during bit 3 of a frame -> all outputs at reset values immediately; no flag; the next frame 8'h0F is received correctly.
